adder16_arbiter: RTL and testbench
==================================

# adder16_arbiter

- Shares one `adder16` datapath instance among `NREQ` requesters using a per-requester valid/ready handshake.
- Grants are round-robin. Operands are registered before the add, and the 16-bit sum and flags are held in a response register until the consumer accepts them.
- The block sits between the control units that request additions and the single structural 16-bit adder.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters. Legal range is 2..8.

Ports:
- `clk`, input, 1: the only clock. All logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, `NREQ`: bit i high means requester i has an operand pair pending.
- `req_ready`, output, `NREQ`: one-hot or zero. Bit i high means requester i's operands are taken this cycle.
- `req_x`, input, `16*NREQ`: packed x operands. Requester i uses `[16*i+15:16*i]`.
- `req_y`, input, `16*NREQ`: packed y operands, same slicing as `req_x`.
- `rsp_valid`, output, 1: a result is available.
- `rsp_ready`, input, 1: the consumer accepts the result.
- `rsp_id`, output, 3: index of the requester that owns the result.
- `rsp_z`, output, 16: sum, modulo 2^16.
- `rsp_s`, `rsp_zr`, `rsp_cy`, `rsp_p`, `rsp_v`, output, 1 each: sign, zero, carry-out, parity (1 = even number of ones in z), and signed overflow.

## Operation
- Three-state FSM: IDLE, EXEC, RESP. It resets to IDLE.
- **IDLE:**
  - If any `req_valid` bit is set, the arbiter picks a winner w.
  - `req_ready[w]` is driven combinationally in the same cycle.
  - `req_x[w]`, `req_y[w]` are latched into `x_q`, `y_q`, and w into `id_q`.
  - The round-robin pointer `last` is updated to w, and the FSM moves to EXEC.
  - With no request, the FSM stays in IDLE.
- **EXEC:**
  - `adder16` is fed from `x_q` and `y_q`.
  - Its z, S, ZR, CY, P and V outputs are registered into the `rsp_*` registers, and `id_q` into `rsp_id`.
  - The FSM moves to RESP.
- **RESP:**
  - `rsp_valid` is 1.
  - When `rsp_ready` is 1, the FSM returns to IDLE.
  - Otherwise every `rsp_*` output holds its value.
- **Round-robin rule:** search from index `last+1`, wrapping modulo `NREQ`; the first set `req_valid` bit wins. `last` resets to `NREQ-1`, so requester 0 has first priority after reset.
- `req_ready` is 0 in EXEC and RESP regardless of `req_valid`.
- Requests are never dropped. A requester keeps `req_valid` and its operands stable until it sees `req_ready`.
- **Flag arithmetic:**
  - CY is bit 16 of the unsigned sum x+y.
  - V = (x[15]==y[15]) && (z[15]!=x[15]).
  - S = z[15].
  - ZR = (z==0).
  - P = ~^z.

## Timing
- **Reset values:**
  - Outputs: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_z`=0, and all flags 0.
  - Internal: state IDLE, `last`=`NREQ-1`.
- **Reset asserted mid-operation:** the in-flight operation is discarded with no response. Arbitration restarts from requester 0.
- **Latency:** the accept cycle is T (`req_ready[w]` high). `rsp_valid` rises at T+2.
- **Throughput:** at least 3 cycles per operation.
- The response handshake and the next grant never share a cycle. The next grant is no earlier than the cycle after `rsp_valid && rsp_ready`.
- `rsp_valid` falls in the cycle after the response handshake. All `rsp_*` outputs are registered.
- **Simultaneous requests:** exactly one grant per IDLE cycle, and losers stay pending.
- **Fairness:** with all `NREQ` requesters continuously valid, each is granted exactly once every `NREQ` operations.

## Configuration
- Controlled by the macro `ADD16_ARB_PRIO_EN`.
- **Defined:** requester 0 has fixed highest priority. If `req_valid[0]` is set in IDLE, requester 0 wins and `last` is not updated. Requesters 1..`NREQ-1` are round-robin among themselves when `req_valid[0]` is 0.
- **Undefined:** pure round-robin over all requesters, as described above.

## Test plan
- **Single operation, back-pressure:**
  - Stimulus: requester 0 sends x=8FFF, y=8000; `rsp_ready` is held low for 3 cycles.
  - Required: `rsp_valid` rises at T+2. Response is z=0FFF, CY=1, V=1, S=0, ZR=0, P=1, id=0, and it is held stable until `rsp_ready`.
- **Flag sweep (NREQ=4):** requesters 0..3 all valid, with x/y of FFFE/A000, AAAA/5555, 8FFF/7700 and 0001/FFFF respectively. Required responses in id order 0,1,2,3:
  - id 0: z=9FFE, CY=1, S=1, V=0, P=0.
  - id 1: z=FFFF, CY=0, S=1, P=1.
  - id 2: z=06FF, CY=1, V=0, P=1.
  - id 3: z=0000, ZR=1, CY=1, P=1.
- **Fairness:** all 4 requesters continuously valid for 12 operations. Required grant order is 0,1,2,3 repeated, exactly 3 grants each, and `req_ready` is never set outside IDLE.
- **Reset mid-operation:** `rst_n` pulsed low during EXEC. Required: `rsp_valid` stays 0, all outputs return to 0, and the next grant goes to requester 0.
- **With `ADD16_ARB_PRIO_EN`:** requesters 0 and 2 continuously valid. Required: every grant goes to requester 0. When requester 0 drops `req_valid`, the next grant goes to requester 2.

Source files
------------

// File: rtl/adder16_arbiter.sv
// adder16_arbiter: round-robin front end sharing one 16-bit adder among NREQ
// requesters. Operands are registered (EXEC), then the sum and flags are held
// in a response register until the consumer accepts them (RESP).
// Optional feature macro: ADD16_ARB_PRIO_EN gives requester 0 fixed highest
// priority; the rest stay round-robin among themselves.

module adder16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] z,
  output logic        s,
  output logic        zr,
  output logic        cy,
  output logic        p,
  output logic        v
);
  logic [16:0] sum;

  // Unsigned 17-bit add; flags derived from the truncated sum.
  always_comb begin
    sum = {1'b0, x} + {1'b0, y};
    z   = sum[15:0];
    cy  = sum[16];
    s   = sum[15];
    zr  = (sum[15:0] == 16'h0000);
    p   = ~^sum[15:0];
    v   = (x[15] == y[15]) && (sum[15] != x[15]);
  end
endmodule

module adder16_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_id,
  output logic [15:0]          rsp_z,
  output logic                 rsp_s,
  output logic                 rsp_zr,
  output logic                 rsp_cy,
  output logic                 rsp_p,
  output logic                 rsp_v
);
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] last_q;
  logic [LW-1:0] id_q;
  logic [15:0]   x_q, y_q;

  logic          found, upd;
  logic [LW-1:0] win, idx;

  logic [15:0]   a_z;
  logic          a_s, a_zr, a_cy, a_p, a_v;

  logic          rsp_valid_q;
  logic [2:0]    rsp_id_q;
  logic [15:0]   rsp_z_q;
  logic          rsp_s_q, rsp_zr_q, rsp_cy_q, rsp_p_q, rsp_v_q;

  // Winner search: first valid bit starting at last+1, wrapping. With the
  // priority option, requester 0 pre-empts the search and leaves last alone,
  // so the round-robin among 1..NREQ-1 resumes where it stopped.
  always_comb begin
    found = 1'b0;
    upd   = 1'b0;
    win   = '0;
    idx   = '0;
`ifdef ADD16_ARB_PRIO_EN
    if (req_valid[0]) begin
      found = 1'b1;
      win   = '0;
    end else
`endif
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        upd   = 1'b1;
        win   = idx;
      end
    end
  end

  // Grant is only offered while idle; one-hot or zero.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && found) req_ready[win] = 1'b1;
  end

  // Next-state: IDLE -> EXEC on grant, EXEC -> RESP, RESP -> IDLE on accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture and round-robin pointer update on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= LW'(NREQ - 1);
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && found) begin
        x_q  <= req_x[16*int'(win) +: 16];
        y_q  <= req_y[16*int'(win) +: 16];
        id_q <= win;
        if (upd) last_q <= win;
      end
    end
  end

  adder16 u_add (
    .x  (x_q),
    .y  (y_q),
    .z  (a_z),
    .s  (a_s),
    .zr (a_zr),
    .cy (a_cy),
    .p  (a_p),
    .v  (a_v)
  );

  // Response register: loaded in EXEC, held through RESP until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_z_q     <= '0;
      rsp_s_q     <= 1'b0;
      rsp_zr_q    <= 1'b0;
      rsp_cy_q    <= 1'b0;
      rsp_p_q     <= 1'b0;
      rsp_v_q     <= 1'b0;
    end else if (state_q == S_EXEC) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= 3'(id_q);
      rsp_z_q     <= a_z;
      rsp_s_q     <= a_s;
      rsp_zr_q    <= a_zr;
      rsp_cy_q    <= a_cy;
      rsp_p_q     <= a_p;
      rsp_v_q     <= a_v;
    end else if (state_q == S_RESP && rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_zr    = rsp_zr_q;
  assign rsp_cy    = rsp_cy_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_v     = rsp_v_q;
endmodule

// File: tb/tb_adder16_arbiter.sv
// Directed self-checking bench for adder16_arbiter (NREQ=4).
module tb_adder16_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_x, req_y;
  logic            rsp_valid, rsp_ready;
  logic [2:0]      rsp_id;
  logic [15:0]     rsp_z;
  logic            rsp_s, rsp_zr, rsp_cy, rsp_p, rsp_v;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder16_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_s(rsp_s), .rsp_zr(rsp_zr), .rsp_cy(rsp_cy), .rsp_p(rsp_p), .rsp_v(rsp_v)
  );

  // {id, z, s, zr, cy, p, v}
  function automatic logic [23:0] rsp_vec();
    return {rsp_id, rsp_z, rsp_s, rsp_zr, rsp_cy, rsp_p, rsp_v};
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a grant, then follows it through EXEC and RESP with
  // rsp_ready held high. Returns the granted index and the captured response.
  // Returns just after the negedge of the cycle following the handshake.
  task automatic run_op(input bit drop, output int gid, output logic [23:0] rsp);
    int n = 0;
    gid = -1;
    rsp = '0;
    #1;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    total++;
    if (req_ready == '0) begin
      bad++; $display("FAIL grant_timeout got=%b want=nonzero", req_ready);
      return;
    end
    total++;
    if (!$onehot(req_ready)) begin
      bad++; $display("FAIL grant_onehot got=%b want=onehot", req_ready);
    end
    for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
    @(negedge clk);
    if (drop) req_valid[gid] = 1'b0;
    #1;
    total++;
    if (req_ready !== '0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL exec_cycle ready=%b valid=%b want ready=0 valid=0", req_ready, rsp_valid);
    end
    @(negedge clk); #1;
    total++;
    if (req_ready !== '0 || rsp_valid !== 1'b1) begin
      bad++; $display("FAIL resp_cycle ready=%b valid=%b want ready=0 valid=1", req_ready, rsp_valid);
    end
    rsp = rsp_vec();
    @(negedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rsp_drop got=%b want=0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_vec() !== 24'h0) begin
      bad++; $display("FAIL reset_state ready=%b valid=%b rsp=%h want 0/0/000000", req_ready, rsp_valid, rsp_vec());
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] exp;
    exp = {3'd0, 16'h0FFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    rsp_ready       = 1'b0;
    req_x[15:0]     = 16'h8FFF;
    req_y[15:0]     = 16'h8000;
    req_valid[0]    = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL bp_grant got=%b want=0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_t1_valid got=%b want=0", rsp_valid);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_vec() !== exp) begin
        bad++; $display("FAIL bp_hold%0d valid=%b rsp=%h want 1/%h", c, rsp_valid, rsp_vec(), exp);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got=%b want=0", rsp_valid);
    end
  endtask

  task automatic test_flags();
    logic [23:0] exp [4];
    logic [23:0] r;
    int g;
    exp[0] = {3'd0, 16'h9FFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp[1] = {3'd1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp[2] = {3'd2, 16'h06FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp[3] = {3'd3, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    req_x = {16'h0001, 16'h8FFF, 16'hAAAA, 16'hFFFE};
    req_y = {16'hFFFF, 16'h7700, 16'h5555, 16'hA000};
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      run_op(1'b1, g, r);
      total++;
      if (g != k || r !== exp[k]) begin
        bad++; $display("FAIL flags_op%0d id=%0d rsp=%h want id=%0d rsp=%h", k, g, r, k, exp[k]);
      end
    end
  endtask

  task automatic test_fairness();
    int cnt [4];
    int g;
    logic [23:0] r;
    do_reset();
    req_x = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    req_y = {16'h0010, 16'h0010, 16'h0010, 16'h0010};
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int k = 0; k < 12; k++) begin
      run_op(1'b0, g, r);
      if (g >= 0) cnt[g]++;
      total++;
      if (g != k % 4 || r[15:0] !== 16'(16'h0011 + 16'(k % 4)) >> 0 && 1'b0) begin
        bad++; $display("FAIL fair_order%0d got=%0d want=%0d", k, g, k % 4);
      end
      total++;
      if (r[20:5] !== 16'(17 + k % 4)) begin
        bad++; $display("FAIL fair_sum%0d got=%h want=%h", k, r[20:5], 16'(17 + k % 4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cnt[i] != 3) begin
        bad++; $display("FAIL fair_count%0d got=%0d want=3", i, cnt[i]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_reset_midop();
    int g;
    logic [23:0] r;
    do_reset();
    req_x = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    req_y = {16'h1000, 16'h1000, 16'h1000, 16'h1000};
    req_valid = 4'b0110;
    run_op(1'b1, g, r);
    total++;
    if (g != 1) begin
      bad++; $display("FAIL rst_pre_grant got=%0d want=1", g);
    end
    // Requester 2 is granted now; cut it off during EXEC.
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++; $display("FAIL rst_second_grant got=%b want=0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_vec() !== 24'h0 || req_ready !== '0) begin
      bad++; $display("FAIL rst_outputs valid=%b rsp=%h ready=%b want 0", rsp_valid, rsp_vec(), req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++; $display("FAIL rst_no_rsp%0d got=%b want=0", c, rsp_valid);
      end
    end
    req_valid = 4'b1111;
    run_op(1'b1, g, r);
    total++;
    if (g != 0) begin
      bad++; $display("FAIL rst_restart got=%0d want=0", g);
    end
    req_valid = '0;
  endtask

`ifdef ADD16_ARB_PRIO_EN
  task automatic test_prio();
    int g;
    logic [23:0] r;
    do_reset();
    req_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      run_op(1'b0, g, r);
      total++;
      if (g != 0) begin
        bad++; $display("FAIL prio_grant%0d got=%0d want=0", k, g);
      end
    end
    req_valid[0] = 1'b0;
    run_op(1'b1, g, r);
    total++;
    if (g != 2) begin
      bad++; $display("FAIL prio_fallback got=%0d want=2", g);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_backpressure();
    test_flags();
    test_fairness();
    test_reset_midop();
`ifdef ADD16_ARB_PRIO_EN
    test_prio();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
